decoder: RTL and testbench
==========================

Name: decoder

Overview:
Receive side of the LightIO optical link. Samples the photodiode line driven by the far-end encoder and recovers one FRAME_SIZE-bit word per frame. Presents the word with a level interrupt held until acknowledged, and flags framing and overrun errors. Sits between the sensor pad and the host-side register/interrupt logic.

Parameters:
FRAME_SIZE, 16 (`FRAME_SIZE from definitions.v), payload bits per frame
BIT_CYCLES, 8, clock cycles per line bit; must be even and >= 4

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
sensor  input  1  raw photodiode level, asynchronous to clock
ack  input  1  host acknowledge; clears irq and overrun
data  output  FRAME_SIZE  last good received word
irq  output  1  high while an unacknowledged good word is held in data
frame_error  output  1  one-cycle pulse on bad stop bit
overrun  output  1  sticky; good word arrived while irq was still high
busy  output  1  high in any state other than IDLE

Behaviour:
- Line format: idle low; start bit high; FRAME_SIZE data bits, MSB first; stop bit low. Each bit is BIT_CYCLES clocks long.
- sensor passes through a 2-flop synchronizer; the FSM uses only the synchronized level s.
- Reset (async): FSM=IDLE, counters=0, synchronizer=0; data=0, irq=0, frame_error=0, overrun=0, busy=0.
- Reset mid-frame aborts the frame; no outputs change other than to their reset values.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: at a rising edge of s (previous 0, current 1), call that clock edge t0; go to START with the counter cleared.
- START: at t0+BIT_CYCLES/2, sample s. If s=1, go to DATA with bit index 0. If s=0, treat it as a glitch: return to IDLE, no error.
- DATA: data bit k (k=0..FRAME_SIZE-1) is sampled at t0+BIT_CYCLES/2+(k+1)*BIT_CYCLES and shifted into the shift register LSB-in, so the first bit received ends as the MSB.
- After bit FRAME_SIZE-1, go to STOP.
- STOP: sample at t0+BIT_CYCLES/2+(FRAME_SIZE+1)*BIT_CYCLES, then go to IDLE.
  - s=0 (good frame): data<=shift register; irq<=1. If irq was already 1 and ack=0 that cycle, overrun<=1 and data is still overwritten.
  - s=1 (bad frame): frame_error pulses high for exactly one cycle; data, irq and overrun are unchanged.
- Updated data, irq and frame_error are visible from the edge after the stop sample.
- IDLE edge detection is level-to-level. If the line is stuck high after a bad stop, no new frame starts until s returns low and rises again.
- Back-to-back frames: the next start edge is accepted in the first IDLE cycle.
- ack=1 clears irq and overrun on the next edge.
- Simultaneous ack and good-frame completion: irq stays 1, data is updated, overrun is cleared (not set).
- ack while irq=0 has no effect.
- busy = (state != IDLE), registered alongside the state.
- Counter width is clog2(BIT_CYCLES); bit index width is clog2(FRAME_SIZE+1). Counters wrap only by explicit clear.

Test Plan:
- Reset with sensor=0 -> all outputs 0, busy=0; an async reset pulse between edges clears them immediately.
- Encode 16'b0100_1111_1011_0110 (0x4FB6), BIT_CYCLES=8 -> irq rises at t0+141, data=0x4FB6, frame_error=0, overrun=0. ack one cycle -> irq=0 next edge, data held.
- Same frame with the stop bit driven high -> frame_error one-cycle pulse at t0+141; irq=0; data keeps its previous value.
- 2-cycle high glitch on sensor from idle -> START sample reads 0, back to IDLE; busy high for 4 cycles only; no irq, no error.
- Two good frames 0x4FB6 then 0x1234, no ack -> data=0x1234, irq=1, overrun=1. Then ack -> irq=0, overrun=0. Repeat with ack asserted exactly at the second completion cycle -> irq=1, overrun=0.
- reset asserted mid-DATA (bit 7) -> busy=0 immediately. A following clean 0xFFFF frame is received correctly with no error.

Source files
------------

// File: rtl/decoder.sv
// decoder: LightIO optical link receiver, recovers one word per frame with irq/error flags
module decoder #(
  parameter int FRAME_SIZE = 16,
  parameter int BIT_CYCLES = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sensor,
  input  logic                  ack,
  output logic [FRAME_SIZE-1:0] data,
  output logic                  irq,
  output logic                  frame_error,
  output logic                  overrun,
  output logic                  busy
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int IW = $clog2(FRAME_SIZE + 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(FRAME_SIZE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  logic [1:0]            sync;
  logic                  s, s_prev;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [FRAME_SIZE-1:0] shift;
  logic                  good, bad;

  assign s = sync[1];

  // two-flop synchronizer plus one-cycle history for rising-edge detection
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sync   <= '0;
      s_prev <= 1'b0;
    end else begin
      sync   <= {sync[0], sensor};
      s_prev <= s;
    end

  // frame FSM: samples mid-bit, shifts MSB-first, flags stop-bit outcome for one cycle
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      good  <= 1'b0;
      bad   <= 1'b0;
    end else begin
      good <= 1'b0;
      bad  <= 1'b0;
      case (state)
        IDLE:
          if (s && !s_prev) begin
            state <= START;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        START:
          if (cnt == HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= s ? DATA : IDLE;
            busy  <= s;
          end else cnt <= cnt + 1'b1;
        DATA:
          if (cnt == LAST) begin
            cnt   <= '0;
            shift <= {shift[FRAME_SIZE-2:0], s};
            idx   <= idx + 1'b1;
            if (idx == LAST_BIT) state <= STOP;
          end else cnt <= cnt + 1'b1;
        STOP:
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            good  <= !s;
            bad   <= s;
          end else cnt <= cnt + 1'b1;
      endcase
    end

  // host-facing outputs update the edge after the stop sample; ack wins over setting overrun
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      data        <= '0;
      irq         <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= bad;
      data        <= good ? shift : data;
      irq         <= good | (irq & ~ack);
      overrun     <= ~ack & (overrun | (good & irq));
    end
endmodule

// File: tb/tb_decoder.sv
// tb_decoder: scoreboard bench for the LightIO receiver
`timescale 1ns/1ps
module tb_decoder;
  logic        clock = 1'b0;
  logic        reset, sensor, ack;
  logic [15:0] data;
  logic        irq, frame_error, overrun, busy;

  decoder dut (
    .clock(clock), .reset(reset), .sensor(sensor), .ack(ack),
    .data(data), .irq(irq), .frame_error(frame_error), .overrun(overrun), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] d;
    logic        irq;
    logic        ov;
    logic        fe;
    int          start;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0, errors = 0, cyc = 0;
  logic        mon_en = 1'b0;
  logic        irq_q = 1'b0, fe_q = 1'b0;
  logic [15:0] data_q = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // monitor: any output event pops the next expected response
  always @(negedge clock) begin
    if (mon_en) begin
      if (fe_q) check("fe_one_cycle", frame_error, 0);
      if (frame_error || (irq && !irq_q) || data != data_q) begin
        if (sb.size() == 0) check("unexpected_event", 1, 0);
        else begin
          e = sb.pop_front();
          check("data", data, e.d);
          check("irq", irq, e.irq);
          check("overrun", overrun, e.ov);
          check("frame_error", frame_error, e.fe);
          check("latency", cyc - e.start, 144);
        end
      end
    end
    irq_q  <= irq;
    fe_q   <= frame_error;
    data_q <= data;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_frame(logic [15:0] w, logic stop);
    sensor = 1'b1;
    tick(8);
    for (int i = 15; i >= 0; i--) begin
      sensor = w[i];
      tick(8);
    end
    sensor = stop;
    tick(8);
    sensor = 1'b0;
  endtask

  task automatic send(logic [15:0] w, logic stop, logic [15:0] ed, logic eirq, logic eov, logic efe);
    sb.push_back('{ed, eirq, eov, efe, cyc});
    drive_frame(w, stop);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      tick(1);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    sensor = 1'b0;
    ack    = 1'b0;
    reset  = 1'b1;
    tick(3);
    check("rst_data", data, 0);
    check("rst_irq", irq, 0);
    check("rst_fe", frame_error, 0);
    check("rst_ov", overrun, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick(2);
    mon_en = 1'b1;

    send(16'h4FB6, 1'b0, 16'h4FB6, 1, 0, 0);
    drain();
    tick(3);
    pulse_ack();
    check("ack_irq", irq, 0);
    check("ack_data", data, 16'h4FB6);

    send(16'h4FB6, 1'b1, 16'h4FB6, 0, 0, 1);
    drain();
    tick(2);
    check("bad_irq", irq, 0);

    sensor = 1'b1;
    tick(2);
    sensor = 1'b0;
    b = 0;
    repeat (20) begin
      tick(1);
      b += int'(busy);
    end
    check("glitch_busy", b, 4);
    check("glitch_irq", irq, 0);

    send(16'h4FB6, 1'b0, 16'h4FB6, 1, 0, 0);
    send(16'h1234, 1'b0, 16'h1234, 1, 1, 0);
    drain();
    check("ovr_irq", irq, 1);
    check("ovr_ov", overrun, 1);
    pulse_ack();
    check("ovr_ack_irq", irq, 0);
    check("ovr_ack_ov", overrun, 0);
    check("ovr_ack_data", data, 16'h1234);

    send(16'h4FB6, 1'b0, 16'h4FB6, 1, 0, 0);
    fork
      send(16'h1234, 1'b0, 16'h1234, 1, 0, 0);
      begin
        tick(142);
        ack = 1'b1;
        tick(2);
        ack = 1'b0;
      end
    join
    drain();
    check("sim_ack_irq", irq, 1);
    check("sim_ack_ov", overrun, 0);
    pulse_ack();

    mon_en = 1'b0;
    sensor = 1'b1;
    tick(68);
    check("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", data, 0);
    check("mid_rst_irq", irq, 0);
    #1 reset = 1'b0;
    sensor = 1'b0;
    tick(10);
    check("post_rst_busy", busy, 0);
    mon_en = 1'b1;
    send(16'hFFFF, 1'b0, 16'hFFFF, 1, 0, 0);
    drain();
    tick(5);
    check("final_fe", frame_error, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
